// File: rtl/q_update_scheduler.sv
// rtl/q_update_scheduler.sv - epsilon-greedy Q-update sequencer: action select, gamma*maxQ, one-hot update strobe
module q_update_scheduler #(
  parameter int          ITER_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  input  logic [15:0]       epsilon,
  input  logic [23:0]       gamma,
  input  logic [23:0]       maxQ_next,
  input  logic [23:0]       q0,
  input  logic [23:0]       q1,
  input  logic [23:0]       q2,
  input  logic [23:0]       q3,
  output logic [3:0]        u,
  output logic [23:0]       gamma_maxQ,
  output logic [1:0]        action,
  output logic              explore,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CALC, S_UPDATE, S_SETTLE, S_DONE
  } state_t;

  state_t            state_q;
  logic [ITER_W-1:0] count_q, iter_done_q, iter_done_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        u_q;
  logic [23:0]       gamma_maxQ_q, gamma_maxQ_d;
  logic [1:0]        action_q, action_d, best_idx;
  logic              explore_q, explore_d;
  logic              busy_q, done_q;

  // Sign-magnitude to two's complement so -0 and +0 compare equal.
  function automatic logic signed [23:0] sm_key(input logic [23:0] v);
    logic signed [23:0] mag;
    mag = $signed({1'b0, v[22:0]});
    return v[23] ? -mag : mag;
  endfunction

  logic [23:0] q_arr [4];
  logic signed [23:0] best_key;
  assign q_arr[0] = q0;
  assign q_arr[1] = q1;
  assign q_arr[2] = q2;
  assign q_arr[3] = q3;

  always_comb begin
    best_idx = 2'd0;
    best_key = sm_key(q_arr[0]);
    for (int i = 1; i < 4; i++) begin
      if (sm_key(q_arr[i]) > best_key) begin
        best_idx = 2'(i);
        best_key = sm_key(q_arr[i]);
      end
    end
  end

  assign explore_d = (lfsr_q < epsilon);
  assign action_d  = explore_d ? lfsr_q[15:14] : best_idx;
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  logic [45:0] prod;
  logic [31:0] prod_hi;
  logic [22:0] prod_mag;
  assign prod     = {23'd0, gamma[22:0]} * {23'd0, maxQ_next[22:0]};
  assign prod_hi  = 32'(prod >> 14);
  assign prod_mag = (|prod_hi[31:23]) ? 23'h7FFFFF : prod_hi[22:0];
  assign gamma_maxQ_d = {(|prod_mag) & (gamma[23] ^ maxQ_next[23]), prod_mag};

  // Holding at all-ones keeps the counter from wrapping on a maximal run.
  assign iter_done_d = (&iter_done_q) ? iter_done_q
                                      : iter_done_q + {{(ITER_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      iter_done_q  <= '0;
      lfsr_q       <= LFSR_SEED;
      u_q          <= '0;
      gamma_maxQ_q <= '0;
      action_q     <= '0;
      explore_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      u_q    <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q     <= iter_count;
            iter_done_q <= '0;
            busy_q      <= 1'b1;
            if (iter_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          action_q  <= action_d;
          explore_q <= explore_d;
          lfsr_q    <= lfsr_d;
          state_q   <= S_CALC;
        end
        S_CALC: begin
          gamma_maxQ_q <= gamma_maxQ_d;
          u_q          <= 4'b0001 << action_q;
          state_q      <= S_UPDATE;
        end
        S_UPDATE: state_q <= S_SETTLE;
        S_SETTLE: begin
          iter_done_q <= iter_done_d;
          if (iter_done_d == count_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_SELECT;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign u          = u_q;
  assign gamma_maxQ = gamma_maxQ_q;
  assign action     = action_q;
  assign explore    = explore_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iter_done  = iter_done_q;

endmodule

// File: tb/tb_q_update_scheduler.sv
// tb/tb_q_update_scheduler.sv - directed self-checking bench for q_update_scheduler
module tb_q_update_scheduler;
  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  iter_count = '0;
  logic [15:0]   epsilon = '0;
  logic [23:0]   gamma = 24'h004000, maxQ_next = 24'h004000;
  logic [23:0]   q0 = '0, q1 = '0, q2 = '0, q3 = '0;
  logic [3:0]    u;
  logic [23:0]   gamma_maxQ;
  logic [1:0]    action;
  logic          explore, busy, done;
  logic [W-1:0]  iter_done;

  q_update_scheduler #(.ITER_W(W), .LFSR_SEED(16'hACE1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .iter_count(iter_count),
    .epsilon(epsilon), .gamma(gamma), .maxQ_next(maxQ_next),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .u(u), .gamma_maxQ(gamma_maxQ), .action(action), .explore(explore),
    .busy(busy), .done(done), .iter_done(iter_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         r_upulses, r_done_cyc;
  logic       r_busy_done, r_busy_after, r_done_after;
  logic [3:0] r_u [$];
  logic       r_e [$];

  task automatic check_all_zero(input string tag);
    check({tag, "_u"}, u, 0);
    check({tag, "_gmq"}, gamma_maxQ, 0);
    check({tag, "_action"}, action, 0);
    check({tag, "_explore"}, explore, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_iter_done"}, iter_done, 0);
  endtask

  // Called at a negedge with the DUT idle; cycle k is the k-th cycle after the accepting edge.
  task automatic do_run(input logic [W-1:0] n, input int restart_at, input int rst_at);
    iter_count = n;
    start = 1'b1;
    r_upulses = 0;
    r_done_cyc = -1;
    r_u.delete();
    r_e.delete();
    @(posedge CLK);
    #1 start = 1'b0;
    for (int k = 1; k <= 4 * int'(n) + 20; k++) begin
      @(negedge CLK);
      start = (k == restart_at);
      if (u != 4'd0) begin
        r_upulses++;
        r_u.push_back(u);
        r_e.push_back(explore);
      end
      if (k == rst_at) begin
        check("u_before_rst", {31'd0, u != 4'd0}, 1);
        RST = 1'b0;
        #1;
        check_all_zero("midrst");
        r_done_cyc = -2;
        break;
      end
      if (done) begin
        r_done_cyc = k;
        r_busy_done = busy;
        break;
      end
    end
    start = 1'b0;
    if (r_done_cyc == -1) check("done_timeout", 0, 1);
    if (r_done_cyc > 0) begin
      @(negedge CLK);
      r_busy_after = busy;
      r_done_after = done;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  logic [15:0] m, v;
  int          extra_u;

  initial begin
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Single greedy iteration: q1 = 3.0 is the maximum.
    epsilon = 16'h0000;
    q0 = 24'h004000; q1 = 24'h00C000; q2 = 24'h008000; q3 = 24'h814000;
    do_run(1, 0, 0);
    check("t1_upulses", r_upulses, 1);
    if (r_u.size() > 0) check("t1_u", r_u[0], 4'b0010);
    check("t1_action", action, 1);
    check("t1_explore", explore, 0);
    check("t1_done_cyc", r_done_cyc, 5);
    check("t1_iter_done", iter_done, 1);
    check("t1_busy_done", r_busy_done, 1);
    check("t1_busy_after", r_busy_after, 0);
    check("t1_done_after", r_done_after, 0);

    // Always-explore run from reset follows the reference LFSR.
    do_reset();
    epsilon = 16'hFFFF;
    do_run(8, 0, 0);
    check("lfsr_upulses", r_upulses, 8);
    check("lfsr_done_cyc", r_done_cyc, 33);
    check("lfsr_iter_done", iter_done, 8);
    m = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      v = m;
      if (i < r_u.size()) begin
        check($sformatf("lfsr_onehot%0d", i), {31'd0, $onehot(r_u[i])}, 1);
        check($sformatf("lfsr_u%0d", i), r_u[i], 4'b0001 << v[15:14]);
        check($sformatf("lfsr_exp%0d", i), r_e[i], {31'd0, v != 16'hFFFF});
      end
      m = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    end
    epsilon = 16'h0000;

    // Multiply cases.
    gamma = 24'h002000; maxQ_next = 24'h010000;
    do_run(1, 0, 0);
    check("mul_pos", gamma_maxQ, 24'h008000);
    maxQ_next = 24'h810000;
    do_run(1, 0, 0);
    check("mul_neg", gamma_maxQ, 24'h808000);
    gamma = 24'h7FFFFF; maxQ_next = 24'h7FFFFF;
    do_run(1, 0, 0);
    check("mul_sat", gamma_maxQ, 24'h7FFFFF);
    maxQ_next = 24'h800000;
    do_run(1, 0, 0);
    check("mul_negzero", gamma_maxQ, 24'h000000);

    // Ties resolve to the lowest index; -0 equals +0.
    q0 = 24'h004000; q1 = 24'h808000; q2 = 24'h004000; q3 = 24'h80C000;
    do_run(1, 0, 0);
    check("tie_u", (r_u.size() > 0) ? r_u[0] : 4'hF, 4'b0001);
    q0 = 24'h800000; q1 = 24'h000000; q2 = 24'h804000; q3 = 24'h808000;
    do_run(1, 0, 0);
    check("tie_zero_u", (r_u.size() > 0) ? r_u[0] : 4'hF, 4'b0001);
    check("tie_zero_action", action, 0);

    // Zero-iteration run.
    do_run(0, 0, 0);
    check("n0_upulses", r_upulses, 0);
    check("n0_done_cyc", r_done_cyc, 1);
    check("n0_iter_done", iter_done, 0);

    // start during a run is ignored.
    q0 = 24'h000000; q1 = 24'h000000; q2 = 24'h000000; q3 = 24'h00C000;
    do_run(3, 6, 0);
    check("restart_upulses", r_upulses, 3);
    check("restart_done_cyc", r_done_cyc, 13);
    check("restart_iter_done", iter_done, 3);
    check("restart_u", (r_u.size() > 2) ? r_u[2] : 4'h0, 4'b1000);

    // Reset asserted in the UPDATE cycle of iteration 2 of 5.
    gamma = 24'h004000; maxQ_next = 24'h004000;
    do_run(5, 0, 7);
    repeat (2) @(negedge CLK);
    check_all_zero("inrst");
    RST = 1'b1;
    extra_u = 0;
    repeat (12) begin
      @(negedge CLK);
      if (u != 4'd0) extra_u++;
    end
    check("postrst_no_u", extra_u, 0);
    check("postrst_busy", busy, 0);
    do_run(1, 0, 0);
    check("postrst_upulses", r_upulses, 1);
    check("postrst_done_cyc", r_done_cyc, 5);
    check("postrst_iter_done", iter_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
